lcd_text_writer: RTL and testbench

LCD_TEXT_WRITER -- requirements
Module: lcd_text_writer

---
 rtl/lcd_text_writer.sv | 153 +++++++++++++++
 tb/tb_lcd_text_writer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_text_writer.sv
// Buffers host text/command entries in a small FIFO and hands them one at a time to an LCD controller.
// Optional macro LCD_TEXT_WRITER_AUTOWRAP_EN inserts line-wrap cursor commands as the column advances.
module lcd_text_writer #(
    parameter int FIFO_DEPTH  = 4,
    parameter int ACK_TIMEOUT = 4095
) (
    input  logic       clock,
    input  logic       internal_reset_n,
    input  logic       wr_en,
    input  logic [8:0] wr_data,
    output logic       full,
    output logic       empty,
    input  logic       busy_flag,
    output logic [8:0] d_out,
    output logic       data_ready,
    output logic       overflow,
    output logic       timeout_err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE
    } state_t;

    state_t state, next_state;

    logic [8:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic [TMR_W-1:0] timer;
    logic [4:0]       column, next_column;
    logic             wrap_pending;
    logic [8:0]       wrap_cmd;
    logic             push, pop, launch, acked, timed_out;

    assign full       = (count == CNT_W'(FIFO_DEPTH));
    assign empty      = (count == '0);
    assign push       = wr_en && !full;
    assign launch     = (state == IDLE) && (!empty || wrap_pending) && !busy_flag;
    assign pop        = launch && !wrap_pending;
    assign acked      = (state == ISSUE) && busy_flag;
    assign timed_out  = (state == ISSUE) && !busy_flag && (timer == TMR_W'(ACK_TIMEOUT - 1));
    assign data_ready = (state == ISSUE);

    always_ff @(posedge clock or negedge internal_reset_n) begin
        if (!internal_reset_n) state <= IDLE;
        else                   state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (launch) next_state = ISSUE;
            ISSUE: begin
                if (busy_flag)      next_state = WAIT_DONE;
                else if (timed_out) next_state = IDLE;
            end
            WAIT_DONE: if (!busy_flag) next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    // Storage carries no reset; the pointers and count define what is valid.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clock or negedge internal_reset_n) begin
        if (!internal_reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (wr_en && full) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge internal_reset_n) begin
        if (!internal_reset_n) begin
            d_out       <= 9'h000;
            timer       <= '0;
            timeout_err <= 1'b0;
            column      <= 5'd0;
        end else begin
            if (launch) d_out <= wrap_pending ? wrap_cmd : mem[rd_ptr];
            if (state == ISSUE && next_state == ISSUE) timer <= timer + 1'b1;
            else                                       timer <= '0;
            if (timed_out) timeout_err <= 1'b1;
            if (acked)     column      <= next_column;
        end
    end

`ifdef LCD_TEXT_WRITER_AUTOWRAP_EN
    logic       wrap_set;
    logic [8:0] wrap_next;
`endif

    // Cursor tracking for the entry currently presented; only applied once the controller takes it.
    always_comb begin
        next_column = column;
`ifdef LCD_TEXT_WRITER_AUTOWRAP_EN
        wrap_set  = 1'b0;
        wrap_next = wrap_cmd;
`endif
        if (d_out[8]) begin
            next_column = column + 5'd1;
`ifdef LCD_TEXT_WRITER_AUTOWRAP_EN
            if (column == 5'd15) begin
                wrap_set  = 1'b1;
                wrap_next = 9'h0C0;
            end else if (column == 5'd31) begin
                wrap_set  = 1'b1;
                wrap_next = 9'h080;
            end
`endif
        end else if (d_out[7:0] == 8'h01 || d_out[7:0] == 8'h02) begin
            next_column = 5'd0;
        end else if (d_out[7]) begin
            next_column = {d_out[6], d_out[3:0]};
        end
    end

`ifdef LCD_TEXT_WRITER_AUTOWRAP_EN
    always_ff @(posedge clock or negedge internal_reset_n) begin
        if (!internal_reset_n) begin
            wrap_pending <= 1'b0;
            wrap_cmd     <= 9'h000;
        end else if (acked && wrap_set) begin
            wrap_pending <= 1'b1;
            wrap_cmd     <= wrap_next;
        end else if (launch) begin
            wrap_pending <= 1'b0;
        end
    end
`else
    assign wrap_pending = 1'b0;
    assign wrap_cmd     = 9'h000;
`endif

endmodule

// File: tb/tb_lcd_text_writer.sv
// Randomized and directed bench for lcd_text_writer, checked every cycle against a queue-based transaction model.
module tb_lcd_text_writer;

    localparam int DEPTH = 4;
    localparam int TMO   = 24;

    localparam int S_IDLE = 0, S_PRES = 1, S_WAIT = 2;
    localparam int L_MANUAL = 0, L_RESP = 1, L_FAST = 2, L_DEAF = 3;

    logic       clock = 1'b0;
    logic       internal_reset_n;
    logic       wr_en;
    logic [8:0] wr_data;
    logic       busy_flag;
    logic       full, empty, data_ready, overflow, timeout_err;
    logic [8:0] d_out;

    always #5 clock = ~clock;

    lcd_text_writer #(.FIFO_DEPTH(DEPTH), .ACK_TIMEOUT(TMO)) dut (
        .clock(clock), .internal_reset_n(internal_reset_n), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .empty(empty), .busy_flag(busy_flag), .d_out(d_out),
        .data_ready(data_ready), .overflow(overflow), .timeout_err(timeout_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: the FIFO is a queue, the controller handshake a transaction phase.
    logic [8:0] mq[$];
    int         m_st, m_age, m_col;
    logic [8:0] m_out, m_wval;
    bit         m_ovf, m_terr, m_wpend;

    int         lcd_mode;
    bit         l_ignore;
    int         l_delay, l_hold;
    logic [8:0] log_q[$];
    bit         prev_dr;

    function automatic void modelReset();
        mq.delete();
        m_st = S_IDLE; m_age = 0; m_col = 0;
        m_out = 9'h000; m_wval = 9'h000;
        m_ovf = 0; m_terr = 0; m_wpend = 0;
    endfunction

    function automatic void modelApply(logic [8:0] e);
        if (e[8]) begin
            m_col = m_col + 1;
`ifdef LCD_TEXT_WRITER_AUTOWRAP_EN
            if (m_col == 16) begin
                m_wpend = 1; m_wval = 9'h0C0;
            end else if (m_col == 32) begin
                m_col = 0; m_wpend = 1; m_wval = 9'h080;
            end
`else
            m_col = m_col % 32;
`endif
        end else if (e[7:0] == 8'h01 || e[7:0] == 8'h02) begin
            m_col = 0;
        end else if (e[7]) begin
            m_col = (e[6] ? 16 : 0) + int'(e[3:0]);
        end
    endfunction

    function automatic void modelStep();
        bit was_full = (mq.size() == DEPTH);
        if (m_st == S_IDLE) begin
            if (!busy_flag && (mq.size() > 0 || m_wpend)) begin
                if (m_wpend) m_out = m_wval;
                else         m_out = mq.pop_front();
                m_wpend = 0;
                m_st = S_PRES; m_age = 0;
            end
        end else if (m_st == S_PRES) begin
            if (busy_flag) begin
                modelApply(m_out);
                m_st = S_WAIT;
            end else if (m_age == TMO - 1) begin
                m_st = S_IDLE; m_terr = 1;
            end else begin
                m_age++;
            end
        end else if (!busy_flag) begin
            m_st = S_IDLE;
        end
        if (wr_en) begin
            if (was_full) m_ovf = 1;
            else          mq.push_back(wr_data);
        end
    endfunction

    task automatic checkValue(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        checkValue("data_ready", 32'(data_ready), 32'(m_st == S_PRES));
        checkValue("d_out", 32'(d_out), 32'(m_out));
        checkValue("full", 32'(full), 32'(mq.size() == DEPTH));
        checkValue("empty", 32'(empty), 32'(mq.size() == 0));
        checkValue("overflow", 32'(overflow), 32'(m_ovf));
        checkValue("timeout_err", 32'(timeout_err), 32'(m_terr));
        checkValue("column", 32'(dut.column), 32'(m_col));
        if (data_ready === 1'b1 && !prev_dr) log_q.push_back(d_out);
        prev_dr = (data_ready === 1'b1);
    endtask

    // LCD controller behaviour, chosen per cycle from the transaction phase.
    task automatic applyStimulus();
        case (lcd_mode)
            L_RESP, L_FAST: begin
                if (m_st == S_IDLE) begin
                    busy_flag = (lcd_mode == L_RESP) && ($urandom % 5 == 0);
                    l_ignore  = (lcd_mode == L_RESP) && ($urandom % 10 == 0);
                    l_delay   = (lcd_mode == L_RESP) ? int'($urandom % 3) : 0;
                    l_hold    = (lcd_mode == L_RESP) ? int'($urandom % 3) : 0;
                end else if (m_st == S_PRES) begin
                    if (l_ignore) busy_flag = 1'b0;
                    else if (l_delay > 0) begin l_delay--; busy_flag = 1'b0; end
                    else busy_flag = 1'b1;
                end else begin
                    if (l_hold > 0) begin l_hold--; busy_flag = 1'b1; end
                    else busy_flag = 1'b0;
                end
            end
            L_DEAF:  busy_flag = 1'b0;
            default: ;
        endcase
    endtask

    task automatic step();
        modelStep();
        @(negedge clock);
        checkOutput();
    endtask

    task automatic doReset();
        internal_reset_n = 1'b0;
        wr_en = 1'b0; busy_flag = 1'b0;
        modelReset();
        prev_dr = 0;
        @(negedge clock);
        checkOutput();
        internal_reset_n = 1'b1;
    endtask

    task automatic drain(int limit);
        int n = 0;
        wr_en = 1'b0;
        while ((mq.size() > 0 || m_st != S_IDLE || m_wpend) && n < limit) begin
            applyStimulus();
            step();
            n++;
        end
        checkValue("drain_bound", 32'(n < limit), 32'd1);
    endtask

    task automatic writeOne(logic [8:0] v);
        wr_en = 1'b1; wr_data = v;
        applyStimulus();
        step();
        wr_en = 1'b0;
    endtask

    initial begin
        int hi;
        int sent;
        int n;
        internal_reset_n = 1'b0;
        wr_en = 1'b0; wr_data = 9'h000; busy_flag = 1'b0;
        lcd_mode = L_MANUAL;
        modelReset();
        @(negedge clock);
        doReset();

        // Held-off issue, then presentation held until the controller takes it.
        busy_flag = 1'b1;
        writeOne(9'h141);
        repeat (3) step();
        checkValue("held_off_ready", 32'(data_ready), 32'd0);
        busy_flag = 1'b0;
        step();
        checkValue("first_ready", 32'(data_ready), 32'd1);
        checkValue("first_dout", 32'(d_out), 32'h141);
        repeat (3) step();
        checkValue("still_ready", 32'(data_ready), 32'd1);
        busy_flag = 1'b1;
        step();
        checkValue("ready_drop", 32'(data_ready), 32'd0);
        busy_flag = 1'b0;
        step();

        // Five writes into a four-deep FIFO while the controller is busy.
        doReset();
        busy_flag = 1'b1;
        for (int i = 0; i < 5; i++) begin
            writeOne(9'h101 + 9'(i));
            if (i == 3) checkValue("full_after_4", 32'(full), 32'd1);
        end
        checkValue("overflow_after_5", 32'(overflow), 32'd1);
        log_q.delete();
        lcd_mode = L_FAST;
        drain(200);
        checkValue("issued_count", 32'(log_q.size()), 32'd4);
        for (int k = 0; k < 4 && k < log_q.size(); k++)
            checkValue("issued_order", 32'(log_q[k]), 32'h101 + 32'(k));

        // Unacknowledged entry times out and the next one goes out normally.
        doReset();
        lcd_mode = L_DEAF;
        writeOne(9'h1AA);
        writeOne(9'h1BB);
        hi = (data_ready === 1'b1) ? 1 : 0;
        for (int i = 0; i < TMO + 10; i++) begin
            applyStimulus();
            step();
            if (data_ready === 1'b1) hi++;
            if (timeout_err === 1'b1) break;
        end
        checkValue("timeout_ready_cycles", 32'(hi), 32'(TMO));
        checkValue("timeout_flag", 32'(timeout_err), 32'd1);
        log_q.delete();
        lcd_mode = L_FAST;
        drain(200);
        checkValue("after_timeout_count", 32'(log_q.size()), 32'd1);
        if (log_q.size() > 0) checkValue("after_timeout_entry", 32'(log_q[0]), 32'h1BB);

        // Cursor position commands.
        doReset();
        lcd_mode = L_FAST;
        writeOne(9'h0C5);
        writeOne(9'h141);
        drain(200);
        checkValue("column_after_c5_char", 32'(dut.column), 32'd22);
        writeOne(9'h001);
        drain(200);
        checkValue("column_after_clear", 32'(dut.column), 32'd0);

        // A full two-line run of characters.
        doReset();
        log_q.delete();
        lcd_mode = L_FAST;
        sent = 0; n = 0;
        while ((sent < 33 || mq.size() > 0 || m_st != S_IDLE || m_wpend) && n < 3000) begin
            if (sent < 33 && mq.size() < DEPTH) begin
                wr_en = 1'b1; wr_data = 9'h141; sent++;
            end else begin
                wr_en = 1'b0;
            end
            applyStimulus();
            step();
            n++;
        end
        wr_en = 1'b0;
        checkValue("char_run_bound", 32'(n < 3000), 32'd1);
`ifdef LCD_TEXT_WRITER_AUTOWRAP_EN
        checkValue("wrap_run_count", 32'(log_q.size()), 32'd35);
        if (log_q.size() == 35) begin
            checkValue("wrap_line2", 32'(log_q[16]), 32'h0C0);
            checkValue("char_17", 32'(log_q[17]), 32'h141);
            checkValue("wrap_line1", 32'(log_q[33]), 32'h080);
            checkValue("char_33", 32'(log_q[34]), 32'h141);
        end
`else
        checkValue("plain_run_count", 32'(log_q.size()), 32'd33);
`endif
        checkValue("column_after_run", 32'(dut.column), 32'd1);

        // Randomized traffic with a loosely behaved controller.
        doReset();
        lcd_mode = L_RESP;
        for (int i = 0; i < 4000; i++) begin
            wr_en   = ($urandom % 3 == 0);
            wr_data = {1'($urandom % 4 != 0), 8'($urandom)};
            if ($urandom % 8 == 0) wr_data = {1'b0, 8'($urandom % 3)};
            applyStimulus();
            step();
        end
        wr_en = 1'b0;

        // Asynchronous reset while an entry is being presented.
        doReset();
        lcd_mode = L_DEAF;
        writeOne(9'h141);
        writeOne(9'h142);
        step();
        checkValue("pre_reset_ready", 32'(data_ready), 32'd1);
        internal_reset_n = 1'b0;
        #1;
        checkValue("async_reset_ready", 32'(data_ready), 32'd0);
        checkValue("async_reset_empty", 32'(empty), 32'd1);
        modelReset();
        prev_dr = 0;
        @(negedge clock);
        checkOutput();
        internal_reset_n = 1'b1;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
